// File: rtl/slice_serial_adder_pkg.sv
// Shared types and helpers for the slice-serial multi-precision adder.
// Holds the FSM state encoding and the slice-index width helper.
package slice_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The slice index never collapses to zero bits, even when SLICES=1.
    function automatic int idx_width(input int slices);
        if (slices <= 1) begin
            return 1;
        end
        return $clog2(slices);
    endfunction

endpackage

// File: rtl/slice_serial_adder_if.sv
// Operand and result valid/ready handshakes of the slice-serial adder.
// The slave modport is the adder's view; the master modport is the producer/consumer view.
interface slice_serial_adder_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );
endinterface

// File: rtl/slice_serial_adder_rca.sv
// Plain n-bit ripple-carry adder.
// It is the single arithmetic chain that the slice-serial wrapper time-shares.
module RCA_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         cin,
    output logic [n-1:0] sum,
    output logic         cout
);
    logic [n:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < n; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[n];
endmodule

// File: rtl/slice_serial_adder.sv
// Multi-precision add/subtract: a W-bit operand pair goes through one N-bit RCA,
// one slice per clock with the carry held in a flop, LSB slice first.
module slice_serial_adder
    import slice_adder_pkg::*;
#(
    parameter int N      = 4,
    parameter int SLICES = 4
) (
    input logic                 clk,
    input logic                 rst,
    slice_serial_adder_if.slave bus
);
    localparam int            W        = N * SLICES;
    localparam int            IW       = idx_width(SLICES);
    localparam logic [IW-1:0] LAST_IDX = IW'(SLICES - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  a_r_q, a_r_d;
    logic [W-1:0]  b_r_q, b_r_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic [N-1:0]  rca_x, rca_y, rca_sum;
    logic          rca_cout;

    assign rca_x = a_r_q[int'(idx_q)*N +: N];
    assign rca_y = b_r_q[int'(idx_q)*N +: N];

    RCA_nbit #(.n(N)) u_rca (
        .x    (rca_x),
        .y    (rca_y),
        .cin  (carry_q),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_r_d    = a_r_q;
        b_r_d    = b_r_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtraction is a + ~b + 1, so cin is irrelevant in that mode.
                    a_r_d   = bus.a;
                    b_r_d   = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[int'(idx_q)*N +: N] = rca_sum;
                carry_d = rca_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    cout_d  = rca_cout;
                    ovf_d   = (a_r_q[W-1] == b_r_q[W-1]) && (rca_sum[N-1] != a_r_q[W-1]);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_r_q    <= '0;
            b_r_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_r_q    <= a_r_d;
            b_r_q    <= b_r_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_slice_serial_adder.sv
// Self-checking bench for slice_serial_adder (N=4, SLICES=4, W=16): directed corner
// cases with literal expectations plus random back-to-back ops against an arithmetic model.
module tb_slice_serial_adder;
    localparam int N      = 4;
    localparam int SLICES = 4;
    localparam int W      = N * SLICES;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    slice_serial_adder_if #(.W(W)) bus ();

    slice_serial_adder #(.N(N), .SLICES(SLICES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: {ovf, cout, result} from plain integer arithmetic.
    function automatic logic [17:0] refCalc(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
        int          sa, sb, s;
        logic [16:0] full;
        logic        c, o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            full = {1'b0, a} - {1'b0, b};
            c    = (a >= b);
            s    = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            c    = full[16];
            s    = sa + sb + int'(cin);
        end
        o = (s > 32767) || (s < -32768);
        return {o, c, full[15:0]};
    endfunction

    // Cycle-level model: phase 0 idle, 1..SLICES running, SLICES+1 result presented.
    int          m_phase = 0;
    logic [17:0] m_pend;
    logic [17:0] m_out;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_out   <= '0;
        end else if (m_phase == 0) begin
            if (bus.in_valid) begin
                m_pend  <= refCalc(bus.a, bus.b, bus.cin, bus.sub);
                m_phase <= 1;
            end
        end else if (m_phase <= SLICES) begin
            if (m_phase == SLICES) m_out <= m_pend;
            m_phase <= m_phase + 1;
        end else if (bus.out_ready) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        checkOutput("in_ready", {31'd0, bus.in_ready}, {31'd0, m_phase == 0});
        checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, m_phase == SLICES + 1});
        if (m_phase == 0 || m_phase == SLICES + 1)
            checkOutput("held_outputs", {14'd0, bus.ovf, bus.cout, bus.result}, {14'd0, m_out});
    end

    // Presents one op and returns once it has been accepted (or the wait bound expires).
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic sub, input bit rand_ready, output bit accepted);
        bit rdy;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        accepted     = 1'b0;
        for (int g = 0; g < 200 && !accepted; g++) begin
            @(negedge clk);
            rdy = bus.in_ready;
            if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            accepted = rdy;
        end
        #1;
        bus.in_valid = 1'b0;
        if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone(input string name, output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        for (int g = 0; g < 40 && !got; g++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = bus.out_valid;
        end
        if (!got) checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic runOp(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic [17:0] exp);
        bit acc;
        int lat;
        @(posedge clk);
        #1;
        applyStimulus(a, b, cin, sub, 1'b0, acc);
        waitDone(name, lat);
        checkOutput({name, "_latency"}, lat, SLICES);
        checkOutput({name, "_result"}, {14'd0, bus.ovf, bus.cout, bus.result}, {14'd0, exp});
    endtask

    initial begin
        bit          acc;
        int          lat;
        logic [17:0] held;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_outputs", {14'd0, bus.ovf, bus.cout, bus.result}, 32'd0);

        checkOutput("model_pin_add", {14'd0, refCalc(16'h7FFF, 16'h0001, 1'b0, 1'b0)}, {14'd0, 2'b10, 16'h8000});
        checkOutput("model_pin_sub", {14'd0, refCalc(16'h0005, 16'h0007, 1'b1, 1'b1)}, {14'd0, 2'b00, 16'hFFFE});
        checkOutput("model_pin_wrap", {14'd0, refCalc(16'h8000, 16'h8000, 1'b0, 1'b0)}, {14'd0, 2'b11, 16'h0000});

        runOp("add_carry_chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, {2'b00, 16'h0100});
        runOp("add_wrap",        16'hFFFF, 16'h0001, 1'b0, 1'b0, {2'b01, 16'h0000});
        runOp("add_cin",         16'h0000, 16'h0000, 1'b1, 1'b0, {2'b00, 16'h0001});
        runOp("add_pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, {2'b10, 16'h8000});
        runOp("add_neg_ovf",     16'h8000, 16'h8000, 1'b0, 1'b0, {2'b11, 16'h0000});
        runOp("sub_borrow",      16'h0005, 16'h0007, 1'b1, 1'b1, {2'b00, 16'hFFFE});
        runOp("sub_ovf",         16'h8000, 16'h0001, 1'b0, 1'b1, {2'b11, 16'h7FFF});

        // Backpressure: result must sit still and no new op may slip in.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, acc);
        waitDone("bp", lat);
        held = {bus.ovf, bus.cout, bus.result};
        checkOutput("bp_result", {14'd0, held}, {14'd0, 2'b00, 16'h2345});
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (i >= 3 && i <= 5);
            bus.a        = 16'hFFFF;
            bus.b        = 16'hFFFF;
            @(negedge clk);
            checkOutput("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            checkOutput("bp_stable", {14'd0, bus.ovf, bus.cout, bus.result}, {14'd0, held});
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        runOp("after_bp", 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, {2'b01, 16'h0000});

        // Reset in the middle of RUN abandons the op.
        @(posedge clk);
        #1;
        applyStimulus(16'h1357, 16'h2468, 1'b0, 1'b0, 1'b0, acc);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrun_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("midrun_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("midrun_rst_result", {16'd0, bus.result}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("midrun_rst_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        // Random back-to-back traffic with random consumer stalls.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
        end
        bus.out_ready = 1'b1;
        repeat (SLICES + 4) @(posedge clk);
        @(negedge clk);
        checkOutput("drain_idle", {31'd0, bus.in_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
